// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result stream bundle for the pipelined adder/subtractor
interface pipelined_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: sliced, carry-pipelined two's-complement add/sub with valid/ready stream
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    pipelined_addsub_if.slave io
);
    localparam int CH = WIDTH / STAGES;
    localparam int XL = WIDTH + CH;

    logic en;
    logic ovf_d;
    logic ovf_q;

    assign en          = !(io.out_valid && !io.out_ready);
    assign io.in_ready = en;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        // Stage input word: {B' bits [WIDTH-1:LO], A/sum word}; bits below LO of the A/sum word already hold sum
        localparam int LO = k * CH;
        localparam int XW = 2 * WIDTH - LO;
        localparam int RW = XW - CH;
        logic [XW-1:0] x;
        logic          ci;
        logic          vi;
        logic          co;
        logic [CH-1:0] s;
        logic [RW-1:0] acc_d;
        logic [RW-1:0] acc_q;
        logic          carry_d;
        logic          carry_q;
        logic          valid_d;
        logic          valid_q;
        if (k == 0) begin : g_src
            assign x  = {io.b ^ {WIDTH{io.sub}}, io.a};
            assign ci = io.sub;
            assign vi = io.in_valid;
        end else begin : g_src
            assign x  = g_stage[k-1].acc_q;
            assign ci = g_stage[k-1].carry_q;
            assign vi = g_stage[k-1].valid_q;
        end
        // Add this slice, splice it into the A/sum word and drop the consumed B' slice
        always_comb begin
            {co, s}         = {1'b0, x[LO +: CH]} + {1'b0, x[WIDTH +: CH]} + {{CH{1'b0}}, ci};
            acc_d           = RW'({x[XW-1:WIDTH] >> CH, x[WIDTH-1:0]});
            acc_d[LO +: CH] = s;
            carry_d         = co;
            valid_d         = vi;
        end
        // Stage registers clear on reset and hold while the output is stalled
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (en) begin
                acc_q   <= acc_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end
    end

    // Signed overflow: A and B' agree in sign but the result sign differs from A
    always_comb begin
        ovf_d = (g_stage[STAGES-1].x[WIDTH-1] == g_stage[STAGES-1].x[XL-1]) &&
                (g_stage[STAGES-1].s[CH-1] != g_stage[STAGES-1].x[WIDTH-1]);
    end

    // Overflow flag registered alongside the final stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign io.out_valid = g_stage[STAGES-1].valid_q;
    assign io.sum       = g_stage[STAGES-1].acc_q;
    assign io.carry_out = g_stage[STAGES-1].carry_q;
    assign io.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: randomized and directed checks of pipelined_addsub against an arithmetic model
module tb_pipelined_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_addsub_if #(.WIDTH(8))  m_if ();
    pipelined_addsub_if #(.WIDTH(16)) s1_if ();
    pipelined_addsub_if #(.WIDTH(16)) s4_if ();
    pipelined_addsub_if #(.WIDTH(32)) s8_if ();

    pipelined_addsub #(.WIDTH(8),  .STAGES(2)) u_m  (.clk(clk), .rst(rst), .io(m_if));
    pipelined_addsub #(.WIDTH(16), .STAGES(1)) u_s1 (.clk(clk), .rst(rst), .io(s1_if));
    pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_s4 (.clk(clk), .rst(rst), .io(s4_if));
    pipelined_addsub #(.WIDTH(32), .STAGES(8)) u_s8 (.clk(clk), .rst(rst), .io(s8_if));

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result packed as {overflow, carry_out, sum[w-1:0]}
    function automatic logic [63:0] model(int w, longint unsigned a, longint unsigned b, logic sub);
        longint unsigned m    = (64'd1 << w) - 1;
        longint unsigned half = 64'd1 << (w - 1);
        longint unsigned u, c, o;
        longint sa, sb, r;
        a  = a & m;
        b  = b & m;
        sa = (a >= half) ? longint'(a) - longint'(m + 1) : longint'(a);
        sb = (b >= half) ? longint'(b) - longint'(m + 1) : longint'(b);
        if (sub) begin
            u = (a - b) & m;
            c = (a >= b) ? 1 : 0;
            r = sa - sb;
        end else begin
            u = (a + b) & m;
            c = ((a + b) >> w) & 1;
            r = sa + sb;
        end
        o = (r >= longint'(half) || r < -longint'(half)) ? 1 : 0;
        return u | (c << w) | (o << (w + 1));
    endfunction

    function automatic logic [63:0] m_res();
        return 64'({m_if.overflow, m_if.carry_out, m_if.sum});
    endfunction

    // Scoreboard on the 8/2 instance: handshakes are judged just before the edge they complete on
    initial forever begin
        @(negedge clk);
        if (rst) exp_q.delete();
        else begin
            if (m_if.out_valid && m_if.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check("spurious_out", 64'(m_if.out_valid), 64'd0);
                else check("stream_result", m_res(), exp_q.pop_front());
            end
            if (m_if.in_valid && m_if.in_ready) exp_q.push_back(model(8, m_if.a, m_if.b, m_if.sub));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic directed(string tag, logic [7:0] a, logic [7:0] b, logic sub, logic [63:0] exp);
        m_if.a = a;
        m_if.b = b;
        m_if.sub = sub;
        m_if.in_valid = 1'b1;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        check({tag, "_early"}, 64'(m_if.out_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 64'(m_if.out_valid), 64'd1);
        check({tag, "_res"}, m_res(), exp);
        @(posedge clk); #1;
        check({tag, "_gone"}, 64'(m_if.out_valid), 64'd0);
    endtask

    task automatic send_m(logic [7:0] a, logic [7:0] b, logic sub);
        bit hs = 0;
        m_if.a = a;
        m_if.b = b;
        m_if.sub = sub;
        m_if.in_valid = 1'b1;
        for (int t = 0; t < 50 && !hs; t++) begin
            @(negedge clk);
            hs = m_if.in_ready;
            @(posedge clk); #1;
        end
        check("send_hs", 64'(hs), 64'd1);
        m_if.in_valid = 1'b0;
    endtask

    task automatic gen_vec(input int w, input int st, input int kind,
                           output longint unsigned a, output longint unsigned b, output logic sub);
        longint unsigned m    = (64'd1 << w) - 1;
        longint unsigned half = 64'd1 << (w - 1);
        longint unsigned alt  = 0;
        for (int i = 0; i < w; i++) if (((i / (w / st)) % 2) == 0) alt |= 64'd1 << i;
        case (kind)
            0: begin a = half - 1; b = 1; sub = 0; end
            1: begin a = half;     b = 1; sub = 1; end
            2: begin a = 0;        b = 0; sub = 1; end
            3: begin a = m;        b = 1; sub = 0; end
            4: begin a = m;        b = m; sub = 1; end
            5: begin a = alt;      b = m; sub = 0; end
            default: begin
                a = longint'($urandom) & m;
                b = longint'($urandom) & m;
                sub = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic sweep_vec(int kind);
        longint unsigned a1, b1, a4, b4, a8, b8;
        logic u1, u4, u8;
        string tag = $sformatf("sw%0d", kind);
        gen_vec(16, 1, kind, a1, b1, u1);
        gen_vec(16, 4, kind, a4, b4, u4);
        gen_vec(32, 8, kind, a8, b8, u8);
        s1_if.a = 16'(a1); s1_if.b = 16'(b1); s1_if.sub = u1; s1_if.in_valid = 1'b1;
        s4_if.a = 16'(a4); s4_if.b = 16'(b4); s4_if.sub = u4; s4_if.in_valid = 1'b1;
        s8_if.a = 32'(a8); s8_if.b = 32'(b8); s8_if.sub = u8; s8_if.in_valid = 1'b1;
        @(posedge clk); #1;
        s1_if.in_valid = 1'b0;
        s4_if.in_valid = 1'b0;
        s8_if.in_valid = 1'b0;
        for (int j = 0; j < 9; j++) begin
            check({tag, "_v16x1"}, 64'(s1_if.out_valid), 64'(j == 0));
            check({tag, "_v16x4"}, 64'(s4_if.out_valid), 64'(j == 3));
            check({tag, "_v32x8"}, 64'(s8_if.out_valid), 64'(j == 7));
            if (j == 0) check({tag, "_r16x1"}, 64'({s1_if.overflow, s1_if.carry_out, s1_if.sum}), model(16, a1, b1, u1));
            if (j == 3) check({tag, "_r16x4"}, 64'({s4_if.overflow, s4_if.carry_out, s4_if.sum}), model(16, a4, b4, u4));
            if (j == 7) check({tag, "_r32x8"}, 64'({s8_if.overflow, s8_if.carry_out, s8_if.sum}), model(32, a8, b8, u8));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int out0;
        logic [31:0] ovs;
        logic [63:0] held;
        m_if.in_valid = 0; m_if.a = 0; m_if.b = 0; m_if.sub = 0; m_if.out_ready = 1;
        s1_if.in_valid = 0; s1_if.a = 0; s1_if.b = 0; s1_if.sub = 0; s1_if.out_ready = 1;
        s4_if.in_valid = 0; s4_if.a = 0; s4_if.b = 0; s4_if.sub = 0; s4_if.out_ready = 1;
        s8_if.in_valid = 0; s8_if.a = 0; s8_if.b = 0; s8_if.sub = 0; s8_if.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(m_if.out_valid), 64'd0);
        check("rst_result", m_res(), 64'd0);
        check("rst_in_ready", 64'(m_if.in_ready), 64'd1);
        check("rst_s8_valid", 64'(s8_if.out_valid), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 64'h100);
        directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 64'h280);
        directed("sub_05_07", 8'h05, 8'h07, 1'b1, 64'h0FE);
        directed("sub_80_01", 8'h80, 8'h01, 1'b1, 64'h37F);
        directed("sub_00_00", 8'h00, 8'h00, 1'b1, 64'h100);

        ovs = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) begin
                m_if.a = 8'($urandom);
                m_if.b = 8'($urandom);
                m_if.sub = 1'($urandom_range(0, 1));
                m_if.in_valid = 1'b1;
                check("stream_in_ready", 64'(m_if.in_ready), 64'd1);
            end else m_if.in_valid = 1'b0;
            @(posedge clk); #1;
            ovs[i] = m_if.out_valid;
        end
        check("stream_pattern", 64'(ovs), 64'h0001_FFFE);
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 4; i++) send_m(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end
            begin
                for (int t = 0; t < 20 && !m_if.out_valid; t++) begin
                    @(posedge clk); #1;
                end
                check("bp_first", 64'(m_if.out_valid), 64'd1);
                m_if.out_ready = 1'b0;
                #1;
                held = m_res();
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("bp_in_ready", 64'(m_if.in_ready), 64'd0);
                    check("bp_hold_valid", 64'(m_if.out_valid), 64'd1);
                    check("bp_hold_result", m_res(), held);
                    @(posedge clk); #1;
                end
                m_if.out_ready = 1'b1;
                #1;
                check("bp_release", 64'(m_if.in_ready), 64'd1);
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_count", 64'(n_out - out0), 64'd4);

        m_if.a = 8'h11; m_if.b = 8'h22; m_if.sub = 1'b0; m_if.in_valid = 1'b1;
        @(posedge clk); #1;
        m_if.a = 8'h33; m_if.b = 8'h44; m_if.sub = 1'b1;
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        out0 = n_out;
        check("rst_pre_valid", 64'(m_if.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(m_if.out_valid), 64'd0);
        check("rst_mid_result", m_res(), 64'd0);
        check("rst_mid_in_ready", 64'(m_if.in_ready), 64'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("rst_post_in_ready", 64'(m_if.in_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_ghost", 64'(n_out - out0), 64'd0);

        for (int k = 0; k < 6; k++) sweep_vec(k);
        for (int r = 0; r < 4; r++) sweep_vec(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface.
- Operands are split into STAGES equal slices. Each pipeline stage adds one slice (least significant slice first) and registers the carry into the next stage, so the carry chain per stage is WIDTH/STAGES bits.
- Per-transaction mode selects add or subtract.
- Provides unsigned carry/borrow and signed overflow flags.
- Sits between operand sources and datapath consumers that need high clock rate and full throughput.

Parameters:
WIDTH, 8, operand and result width in bits; must be an integer multiple of STAGES.
STAGES, 2, number of pipeline stages (slices); 1 <= STAGES <= WIDTH; latency equals STAGES.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand transaction valid
in_ready  output  1  block can accept a transaction this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0: A+B; 1: A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
sum  output  WIDTH  result, modulo 2^WIDTH
carry_out  output  1  add: carry out of MSB; sub: 1 = no borrow (A >= B unsigned)
overflow  output  1  signed two's-complement overflow of the operation

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1, every pipeline register clears: all stage valid bits 0, all data and carry registers 0. Outputs during reset: out_valid=0, sum=0, carry_out=0, overflow=0. in_ready is 1 during and after reset.
- Reset mid-operation: all in-flight transactions are discarded, and no result for them is ever produced.
- Slicing: CH = WIDTH/STAGES. Stage k computes bits [k*CH +: CH].
- Subtract: B is inverted and the carry into stage 0 is sub, so A-B = A + ~B + 1.
- Operand skew: each stage registers the not-yet-consumed upper slices of A and ~B/B, plus the sub bit. It also registers the already-computed lower sum slices, so each transaction's slices stay aligned.
- Final stage produces:
  - the full sum;
  - carry_out = carry out of bit WIDTH-1;
  - overflow = carry into MSB XOR carry out of MSB, equivalently (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is the effective operand.
- Latency: a transaction accepted on rising edge N (in_valid && in_ready) appears with out_valid=1 immediately after edge N+STAGES-1. For STAGES=1, it is visible in the cycle after acceptance.
- Handshake:
  - Global advance enable: en = !(out_valid && !out_ready).
  - in_ready = en, a combinational function of out_valid and out_ready only, never of in_valid.
  - When en=1, every stage register loads from its predecessor. Stage 0 loads the valid bit in_valid && in_ready.
  - When en=0, all stage registers hold. out_* stay stable and are not re-evaluated from the inputs.
  - Bubbles (invalid stages) propagate and are not collapsed.
- Throughput: one transaction per cycle while out_ready=1.
- Output acceptance: a result leaves on an edge where out_valid && out_ready. Accepting an output and a new input on the same edge is legal and loses nothing.
- sum, carry_out and overflow are don't-care when out_valid=0, except during reset (forced 0).
- Modular arithmetic throughout: no saturation. Flags are informational only.

Test Plan:
1. WIDTH=8, STAGES=2, out_ready=1. Add FF+01 -> sum=00, carry_out=1, overflow=0, out_valid exactly 2 cycles after accept. Add 7F+01 -> sum=80, carry_out=0, overflow=1 (checks carry crossing the slice boundary).
2. Subtract 05-07 -> sum=FE, carry_out=0, overflow=0. Subtract 80-01 -> sum=7F, carry_out=1, overflow=1. Subtract 00-00 -> sum=00, carry_out=1, overflow=0.
3. Streaming: 16 back-to-back random add/sub transactions with in_valid=1 and out_ready=1 -> 16 consecutive out_valid cycles, results in order, all matching a reference model, in_ready=1 throughout.
4. Backpressure: stream 4 transactions, drop out_ready for 3 cycles after the first result -> in_ready=0 in exactly those cycles; outputs held stable; no loss or duplication; order preserved after release.
5. Reset mid-operation: assert rst asynchronously (between edges) with 2 transactions in flight -> out_valid=0 and sum=0 immediately; after release, in_ready=1 and neither lost transaction ever appears.
6. Parameter sweep (WIDTH,STAGES) = (16,1), (16,4), (32,8), each with the corner vectors: max+1, min-1, 0-0, and operands with all-ones slices -> correct results with latency = STAGES.
